matrix_op_executor: RTL and testbench

- Downstream consumer of the operation selector. Accepts one fully-resolved operation: calc type, operand IDs, scalar, operand dimensions and result slot ID.
- Reads operand elements from matrix storage through a 1-cycle-latency read port. Computes transpose, add, multiply or scalar-multiply, and writes the result to storage in row-major order.
- Pulses done or error when finished.

---
 rtl/matrix_op_executor_pkg.sv | 20 ++
 rtl/matrix_op_selector_pkg.sv | 11 +
 rtl/matrix_exec_alu.sv | 67 ++++++
 rtl/matrix_op_executor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_matrix_op_executor.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_op_executor_pkg.sv
// Executor FSM states and error causes reported on err_code.
package matrix_op_executor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_A,
        RD_B,
        ACC,
        WRITE,
        DONE,
        ERROR
    } exec_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_DIM   = 2'd1;
    localparam logic [1:0] ERR_SHAPE = 2'd2;
    localparam logic [1:0] ERR_ALIAS = 2'd3;

endpackage

// File: rtl/matrix_op_selector_pkg.sv
// Operation encoding shared between the operation selector and its executor.
package matrix_op_selector_pkg;

    typedef enum logic [1:0] {
        CALC_TRANSPOSE  = 2'd0,
        CALC_ADD        = 2'd1,
        CALC_MUL        = 2'd2,
        CALC_SCALAR_MUL = 2'd3
    } calc_type_t;

endpackage

// File: rtl/matrix_exec_alu.sv
// Combinational element datapath: pass, add, scalar product or multiply-accumulate, then narrow to
// DATA_WIDTH (wrap, or clamp when MATRIX_EXEC_SATURATE_EN is defined). Zero latency, no flow control.
module matrix_exec_alu
    import matrix_op_selector_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 67
) (
    input  calc_type_t                    i_calc,
    input  logic signed [DATA_WIDTH-1:0]  i_rd_data,
    input  logic signed [DATA_WIDTH-1:0]  i_a_dat,
    input  logic signed [DATA_WIDTH-1:0]  i_scalar,
    input  logic signed [ACC_WIDTH-1:0]   i_acc,
    output logic signed [ACC_WIDTH-1:0]   o_acc_nxt,
    output logic        [DATA_WIDTH-1:0]  o_res
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] w_mul_op;
    logic signed [PW-1:0]         w_mul_x;
    logic signed [PW-1:0]         w_mul_y;
    logic signed [PW-1:0]         w_prod;
    logic signed [ACC_WIDTH-1:0]  w_rd_ext;
    logic signed [ACC_WIDTH-1:0]  w_a_ext;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;

    // One multiplier serves both MUL (A*B) and SCALAR_MUL (scalar*A).
    assign w_mul_op   = (i_calc == CALC_MUL) ? i_a_dat : i_scalar;
    assign w_mul_x    = {{DATA_WIDTH{w_mul_op[DATA_WIDTH-1]}}, w_mul_op};
    assign w_mul_y    = {{DATA_WIDTH{i_rd_data[DATA_WIDTH-1]}}, i_rd_data};
    assign w_prod     = w_mul_x * w_mul_y;
    assign w_rd_ext   = {{(ACC_WIDTH-DATA_WIDTH){i_rd_data[DATA_WIDTH-1]}}, i_rd_data};
    assign w_a_ext    = {{(ACC_WIDTH-DATA_WIDTH){i_a_dat[DATA_WIDTH-1]}}, i_a_dat};
    assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};

    always_comb begin
        o_acc_nxt = w_rd_ext;
        case (i_calc)
            CALC_TRANSPOSE:  o_acc_nxt = w_rd_ext;
            CALC_ADD:        o_acc_nxt = w_a_ext + w_rd_ext;
            CALC_MUL:        o_acc_nxt = i_acc + w_prod_ext;
            CALC_SCALAR_MUL: o_acc_nxt = w_prod_ext;
            default:         o_acc_nxt = w_rd_ext;
        endcase
    end

`ifdef MATRIX_EXEC_SATURATE_EN
    logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
    logic                          w_ovf;

    // Fits in DATA_WIDTH only when every bit above the result sign bit matches it.
    assign w_hi  = o_acc_nxt[ACC_WIDTH-1:DATA_WIDTH-1];
    assign w_ovf = !((&w_hi) || !(|w_hi));

    always_comb begin
        o_res = o_acc_nxt[DATA_WIDTH-1:0];
        if (w_ovf && (i_calc != CALC_TRANSPOSE)) begin
            o_res = o_acc_nxt[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign o_res = o_acc_nxt[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/matrix_op_executor.sv
// Executes one matrix op against 1-cycle-latency storage, writing results row-major; done/error pulse at end.
// No backpressure: start is ignored while busy. Saturating results under MATRIX_EXEC_SATURATE_EN.
module matrix_op_executor
    import matrix_op_selector_pkg::*;
    import matrix_op_executor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3,
    parameter int DIM_WIDTH  = 3,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + DIM_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  calc_type_t                   calc_type,
    input  logic [ID_WIDTH-1:0]          id_a,
    input  logic [ID_WIDTH-1:0]          id_b,
    input  logic [ID_WIDTH-1:0]          res_id,
    input  logic [DIM_WIDTH-1:0]         m_a,
    input  logic [DIM_WIDTH-1:0]         n_a,
    input  logic [DIM_WIDTH-1:0]         m_b,
    input  logic [DIM_WIDTH-1:0]         n_b,
    input  logic signed [DATA_WIDTH-1:0] scalar,
    output logic                         rd_en,
    output logic [ID_WIDTH-1:0]          rd_id,
    output logic [DIM_WIDTH-1:0]         rd_row,
    output logic [DIM_WIDTH-1:0]         rd_col,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         wr_en,
    output logic [ID_WIDTH-1:0]          wr_id,
    output logic [DIM_WIDTH-1:0]         wr_row,
    output logic [DIM_WIDTH-1:0]         wr_col,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DIM_WIDTH-1:0]         res_m,
    output logic [DIM_WIDTH-1:0]         res_n,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code
);

    exec_state_t                  r_state;
    calc_type_t                   r_calc;
    logic [ID_WIDTH-1:0]          r_id_a, r_id_b, r_res_id;
    logic [DIM_WIDTH-1:0]         r_m_a, r_n_a, r_m_b, r_n_b;
    logic signed [DATA_WIDTH-1:0] r_scalar;
    logic [DIM_WIDTH-1:0]         r_row, r_col, r_k;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [DATA_WIDTH-1:0] r_a_dat;

    logic                         r_rd_en, r_wr_en, r_busy, r_done, r_error;
    logic [ID_WIDTH-1:0]          r_rd_id, r_wr_id;
    logic [DIM_WIDTH-1:0]         r_rd_row, r_rd_col, r_wr_row, r_wr_col;
    logic [DATA_WIDTH-1:0]        r_wr_data;
    logic [DIM_WIDTH-1:0]         r_res_m, r_res_n;
    logic [1:0]                   r_err_code;

    logic                         w_two_op;
    logic [1:0]                   w_err;
    logic                         w_col_wrap, w_last;
    logic [DIM_WIDTH-1:0]         w_row_nxt, w_col_nxt, w_k_nxt;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic [DATA_WIDTH-1:0]        w_res;

    // Address of the A element feeding result (row, col) at inner index k.
    function automatic logic [2*DIM_WIDTH-1:0] a_addr(input calc_type_t      t,
                                                      input logic [DIM_WIDTH-1:0] row,
                                                      input logic [DIM_WIDTH-1:0] col,
                                                      input logic [DIM_WIDTH-1:0] k);
        case (t)
            CALC_TRANSPOSE: return {col, row};
            CALC_MUL:       return {row, k};
            default:        return {row, col};
        endcase
    endfunction

    matrix_exec_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_alu (
        .i_calc    (r_calc),
        .i_rd_data (rd_data),
        .i_a_dat   (r_a_dat),
        .i_scalar  (r_scalar),
        .i_acc     (r_acc),
        .o_acc_nxt (w_acc_nxt),
        .o_res     (w_res)
    );

    assign w_two_op = (r_calc == CALC_ADD) || (r_calc == CALC_MUL);

    always_comb begin
        w_err = ERR_NONE;
        if ((r_m_a == '0) || (r_n_a == '0) || (w_two_op && ((r_m_b == '0) || (r_n_b == '0)))) begin
            w_err = ERR_DIM;
        end else if (((r_calc == CALC_ADD) && ((r_m_a != r_m_b) || (r_n_a != r_n_b))) ||
                     ((r_calc == CALC_MUL) && (r_n_a != r_m_b))) begin
            w_err = ERR_SHAPE;
        end else if ((r_res_id == r_id_a) || (w_two_op && (r_res_id == r_id_b))) begin
            w_err = ERR_ALIAS;
        end
    end

    always_comb begin
        w_col_wrap = (r_col == r_res_n - DIM_WIDTH'(1));
        w_last     = w_col_wrap && (r_row == r_res_m - DIM_WIDTH'(1));
        w_row_nxt  = w_col_wrap ? r_row + DIM_WIDTH'(1) : r_row;
        w_col_nxt  = w_col_wrap ? '0 : r_col + DIM_WIDTH'(1);
        w_k_nxt    = r_k + DIM_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_calc     <= CALC_TRANSPOSE;
            r_id_a     <= '0;
            r_id_b     <= '0;
            r_res_id   <= '0;
            r_m_a      <= '0;
            r_n_a      <= '0;
            r_m_b      <= '0;
            r_n_b      <= '0;
            r_scalar   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_a_dat    <= '0;
            r_rd_en    <= 1'b0;
            r_rd_id    <= '0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_id    <= '0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
            r_wr_data  <= '0;
            r_res_m    <= '0;
            r_res_n    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            // Strobes are single-cycle; only one transition per cycle can raise one, so rd/wr never overlap.
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_calc     <= calc_type;
                        r_id_a     <= id_a;
                        r_id_b     <= id_b;
                        r_res_id   <= res_id;
                        r_m_a      <= m_a;
                        r_n_a      <= n_a;
                        r_m_b      <= m_b;
                        r_n_b      <= n_b;
                        r_scalar   <= scalar;
                        r_err_code <= ERR_NONE;
                        r_res_m    <= '0;
                        r_res_n    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_err != ERR_NONE) begin
                        r_err_code <= w_err;
                        r_error    <= 1'b1;
                        r_state    <= ERROR;
                    end else begin
                        case (r_calc)
                            CALC_TRANSPOSE: begin r_res_m <= r_n_a; r_res_n <= r_m_a; end
                            CALC_MUL:       begin r_res_m <= r_m_a; r_res_n <= r_n_b; end
                            default:        begin r_res_m <= r_m_a; r_res_n <= r_n_a; end
                        endcase
                        r_row                <= '0;
                        r_col                <= '0;
                        r_k                  <= '0;
                        r_acc                <= '0;
                        r_rd_en              <= 1'b1;
                        r_rd_id              <= r_id_a;
                        {r_rd_row, r_rd_col} <= a_addr(r_calc, '0, '0, '0);
                        r_state              <= RD_A;
                    end
                end
                RD_A: begin
                    if (w_two_op) begin
                        r_rd_en  <= 1'b1;
                        r_rd_id  <= r_id_b;
                        r_rd_row <= (r_calc == CALC_MUL) ? r_k : r_row;
                        r_rd_col <= r_col;
                        r_state  <= RD_B;
                    end else begin
                        r_state <= ACC;
                    end
                end
                RD_B: begin
                    // rd_data currently carries the A element requested in RD_A.
                    r_a_dat <= rd_data;
                    r_state <= ACC;
                end
                ACC: begin
                    r_acc     <= w_acc_nxt;
                    r_wr_data <= w_res;
                    r_k       <= w_k_nxt;
                    if ((r_calc == CALC_MUL) && (w_k_nxt != r_n_a)) begin
                        r_rd_en              <= 1'b1;
                        r_rd_id              <= r_id_a;
                        {r_rd_row, r_rd_col} <= a_addr(r_calc, r_row, r_col, w_k_nxt);
                        r_state              <= RD_A;
                    end else begin
                        r_wr_en  <= 1'b1;
                        r_wr_id  <= r_res_id;
                        r_wr_row <= r_row;
                        r_wr_col <= r_col;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_row                <= w_row_nxt;
                        r_col                <= w_col_nxt;
                        r_k                  <= '0;
                        r_acc                <= '0;
                        r_rd_en              <= 1'b1;
                        r_rd_id              <= r_id_a;
                        {r_rd_row, r_rd_col} <= a_addr(r_calc, w_row_nxt, w_col_nxt, '0);
                        r_state              <= RD_A;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                ERROR: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_id    = r_rd_id;
    assign rd_row   = r_rd_row;
    assign rd_col   = r_rd_col;
    assign wr_en    = r_wr_en;
    assign wr_id    = r_wr_id;
    assign wr_row   = r_wr_row;
    assign wr_col   = r_wr_col;
    assign wr_data  = r_wr_data;
    assign res_m    = r_res_m;
    assign res_n    = r_res_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_matrix_op_executor.sv
// Directed table-driven bench for matrix_op_executor with a behavioural 1-cycle-latency storage model.
module tb_matrix_op_executor;
    import matrix_op_selector_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    calc_type_t         calc_type = CALC_TRANSPOSE;
    logic [2:0]         id_a = '0, id_b = '0, res_id = '0;
    logic [2:0]         m_a = '0, n_a = '0, m_b = '0, n_b = '0;
    logic signed [31:0] scalar = '0;
    logic signed [31:0] rd_data = '0;
    logic               rd_en, wr_en, busy, done, error;
    logic [2:0]         rd_id, rd_row, rd_col, wr_id, wr_row, wr_col, res_m, res_n;
    logic [31:0]        wr_data;
    logic [1:0]         err_code;

    matrix_op_executor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .calc_type(calc_type),
        .id_a(id_a), .id_b(id_b), .res_id(res_id),
        .m_a(m_a), .n_a(n_a), .m_b(m_b), .n_b(n_b), .scalar(scalar),
        .rd_en(rd_en), .rd_id(rd_id), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_id(wr_id), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .res_m(res_m), .res_n(res_n), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        calc_type_t  calc;
        logic [2:0]  id_a, id_b, res_id, m_a, n_a, m_b, n_b;
        logic [31:0] scalar;
        logic [1:0]  exp_err;
        logic [2:0]  exp_m, exp_n;
        int          exp_lat, exp_nrd, exp_gap, exp_nw;
        logic [31:0] dat [6];
    } vec_t;

    typedef struct {
        int          id, row, col, cyc;
        logic [31:0] dat;
    } wr_t;

    logic [31:0] mem [8][8][8];
    wr_t         wlog [$];
    wr_t         went;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          overlap = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vt [7];

`ifdef MATRIX_EXEC_SATURATE_EN
    localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h0000_0000;
`endif

    // Storage model: operands are (re)loaded during reset; result slots keep what was written.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mem[0][0][0] <= 1;  mem[0][0][1] <= 2;  mem[0][0][2] <= 3;
            mem[0][1][0] <= 4;  mem[0][1][1] <= 5;  mem[0][1][2] <= 6;
            mem[1][0][0] <= 1;  mem[1][0][1] <= -2; mem[1][1][0] <= 3;  mem[1][1][1] <= 4;
            mem[3][0][0] <= 10; mem[3][0][1] <= 20; mem[3][1][0] <= 30; mem[3][1][1] <= -40;
            mem[4][0][0] <= 1;  mem[4][0][1] <= 2;  mem[4][1][0] <= 3;  mem[4][1][1] <= 4;
            mem[5][0][0] <= 5;  mem[5][0][1] <= 6;  mem[5][1][0] <= 7;  mem[5][1][1] <= 8;
            mem[6][0][0] <= 32'h4000_0000;
        end
        if (rd_en) begin
            rd_data <= mem[rd_id][rd_row][rd_col];
            rd_cnt  <= rd_cnt + 1;
        end
        if (wr_en) begin
            mem[wr_id][wr_row][wr_col] <= wr_data;
            went.id  = int'(wr_id);
            went.row = int'(wr_row);
            went.col = int'(wr_col);
            went.cyc = cyc;
            went.dat = wr_data;
            wlog.push_back(went);
        end
        if (rd_en && wr_en) overlap <= overlap + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input calc_type_t c, input logic [2:0] ia, input logic [2:0] ib,
                                input logic [2:0] ir, input logic [2:0] ma, input logic [2:0] na,
                                input logic [2:0] mb, input logic [2:0] nb, input logic [31:0] sc,
                                input logic [1:0] ee, input logic [2:0] em, input logic [2:0] en,
                                input int lat, input int nrd, input int gap, input int nw,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5);
        vec_t v;
        v.calc = c; v.id_a = ia; v.id_b = ib; v.res_id = ir;
        v.m_a = ma; v.n_a = na; v.m_b = mb; v.n_b = nb; v.scalar = sc;
        v.exp_err = ee; v.exp_m = em; v.exp_n = en;
        v.exp_lat = lat; v.exp_nrd = nrd; v.exp_gap = gap; v.exp_nw = nw;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3; v.dat[4] = d4; v.dat[5] = d5;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        calc_type = v.calc; id_a = v.id_a; id_b = v.id_b; res_id = v.res_id;
        m_a = v.m_a; n_a = v.n_a; m_b = v.m_b; n_b = v.n_b; scalar = v.scalar;
    endtask

    task automatic run_op(input vec_t v, input int idx, input bit inject);
        int t0, base, rd0, lat, nw;
        drive(v);
        base  = wlog.size();
        rd0   = rd_cnt;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_in_check", idx), busy, 1);
        for (int i = 0; i < 300; i++) begin
            if (done || error) break;
            if (inject && i == 4) begin
                start = 1'b1; calc_type = CALC_ADD; res_id = 3'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        lat = cyc - t0;
        check($sformatf("v%0d_finished", idx), done || error, 1);
        check($sformatf("v%0d_done", idx), done, v.exp_err == 2'd0);
        check($sformatf("v%0d_error", idx), error, v.exp_err != 2'd0);
        check($sformatf("v%0d_err_code", idx), err_code, v.exp_err);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        if (v.exp_err == 2'd0) begin
            check($sformatf("v%0d_res_m", idx), res_m, v.exp_m);
            check($sformatf("v%0d_res_n", idx), res_n, v.exp_n);
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), busy, 0);
        check($sformatf("v%0d_pulse_len", idx), done || error, 0);
        check($sformatf("v%0d_reads", idx), rd_cnt - rd0, v.exp_nrd);
        nw = wlog.size() - base;
        check($sformatf("v%0d_writes", idx), nw, v.exp_nw);
        for (int i = 0; i < v.exp_nw && i < nw; i++) begin
            check($sformatf("v%0d_wr%0d_id", idx, i), wlog[base+i].id, v.res_id);
            check($sformatf("v%0d_wr%0d_row", idx, i), wlog[base+i].row, i / int'(v.exp_n));
            check($sformatf("v%0d_wr%0d_col", idx, i), wlog[base+i].col, i % int'(v.exp_n));
            check($sformatf("v%0d_wr%0d_dat", idx, i), wlog[base+i].dat, v.dat[i]);
            if (i > 0 && v.exp_gap != 0)
                check($sformatf("v%0d_wr%0d_gap", idx, i), wlog[base+i].cyc - wlog[base+i-1].cyc, v.exp_gap);
        end
    endtask

    initial begin
        int base, rd_snap;
        vt[0] = mk(CALC_TRANSPOSE,  0, 0, 2, 2, 3, 0, 0, 0, 2'd0, 3, 2, 20, 6, 3, 6,
                   1, 4, 2, 5, 3, 6);
        vt[1] = mk(CALC_ADD,        1, 3, 2, 2, 2, 2, 2, 0, 2'd0, 2, 2, 18, 8, 4, 4,
                   11, 18, 33, -36, 0, 0);
        vt[2] = mk(CALC_MUL,        4, 5, 2, 2, 2, 2, 2, 0, 2'd0, 2, 2, 30, 16, 7, 4,
                   19, 22, 43, 50, 0, 0);
        vt[3] = mk(CALC_SCALAR_MUL, 6, 0, 2, 1, 1, 0, 0, 4, 2'd0, 1, 1, 5, 1, 0, 1,
                   SAT_EXP, 0, 0, 0, 0, 0);
        vt[4] = mk(CALC_ADD,        1, 3, 2, 2, 3, 3, 2, 0, 2'd2, 0, 0, 2, 0, 0, 0,
                   0, 0, 0, 0, 0, 0);
        vt[5] = mk(CALC_TRANSPOSE,  0, 0, 2, 0, 3, 0, 0, 0, 2'd1, 0, 0, 2, 0, 0, 0,
                   0, 0, 0, 0, 0, 0);
        vt[6] = mk(CALC_TRANSPOSE,  0, 0, 0, 2, 3, 0, 0, 0, 2'd3, 0, 0, 2, 0, 0, 0,
                   0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_res_m", res_m, 0);
        check("rst_res_n", res_n, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        for (int v = 0; v < 7; v++) run_op(vt[v], v, 1'b0);

        // Second start mid-operation must be ignored.
        run_op(vt[0], 7, 1'b1);

        // Reset right after the second multiply write.
        drive(vt[2]);
        base  = wlog.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && (wlog.size() - base) < 2; i++) @(negedge clk);
        check("abort_two_writes", wlog.size() - base, 2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        rd_snap = rd_cnt;
        repeat (3) @(negedge clk);
        check("abort_no_writes", wlog.size() - base, 2);
        check("abort_no_reads", rd_cnt - rd_snap, 0);
        check("abort_kept_elem", mem[2][0][1], 22);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(vt[2], 8, 1'b0);

        check("rd_wr_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
